// File: rtl/clarvi_load_unit_if.sv
// clarvi_load_unit_if: bundles the load-return stage's pipeline-side signals.
// issue_width encoding: 0 = B, 1 = H, 2 = W, 3 = D.
// master = request/memory side (drives issues and returns, sees results);
// slave  = the load unit itself.
interface clarvi_load_unit_if #(
  parameter int PENDING_DEPTH = 2
);
  logic                             stall;
  logic                             issue_read;
  logic [1:0]                       issue_width;
  logic                             issue_unsigned;
  logic [2:0]                       issue_offset;
  logic [4:0]                       issue_rd;
  logic [63:0]                      read_data;
  logic                             read_data_valid;
  logic                             load_valid;
  logic [4:0]                       load_rd;
  logic [63:0]                      load_value;
  logic                             stall_for_memory_pending;
  logic [$clog2(PENDING_DEPTH):0]   outstanding;
  logic                             load_timeout;

  modport master (
    output stall, issue_read, issue_width, issue_unsigned, issue_offset, issue_rd,
    output read_data, read_data_valid,
    input  load_valid, load_rd, load_value, stall_for_memory_pending,
    input  outstanding, load_timeout
  );

  modport slave (
    input  stall, issue_read, issue_width, issue_unsigned, issue_offset, issue_rd,
    input  read_data, read_data_valid,
    output load_valid, load_rd, load_value, stall_for_memory_pending,
    output outstanding, load_timeout
  );
endinterface

// File: rtl/clarvi_load_unit.sv
// clarvi_load_unit: in-order load-return stage. Queues metadata of issued
// reads, then aligns/extends the returning 64-bit word into a registered
// writeback result one cycle after the return.
// Optional feature: define LOAD_TIMEOUT_EN to abandon a head entry that has
// waited TIMEOUT_CYCLES without a return (pulses load_timeout).
module clarvi_load_unit #(
  parameter int PENDING_DEPTH  = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clock,
  input  logic               reset,
  clarvi_load_unit_if.slave  bus
);

  localparam int PW = $clog2(PENDING_DEPTH);
  localparam int CW = PW + 1;

  // Reject configurations the pointer arithmetic cannot handle.
  if (PENDING_DEPTH < 2 || (PENDING_DEPTH & (PENDING_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1)
  begin : g_bad_cfg
    $error("clarvi_load_unit: PENDING_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {
    WIDTH_B = 2'd0,
    WIDTH_H = 2'd1,
    WIDTH_W = 2'd2,
    WIDTH_D = 2'd3
  } mem_width_t;

  typedef struct packed {
    mem_width_t  width;
    logic        is_unsigned;
    logic [2:0]  offset;
    logic [4:0]  rd;
  } entry_t;

  entry_t          r_queue [PENDING_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_load_valid;
  logic [4:0]      r_load_rd;
  logic [63:0]     r_load_value;

  entry_t          w_head;
  logic            w_full;
  logic            w_pop;
  logic            w_expire;
  logic            w_deq;
  logic            w_push;
  logic [63:0]     w_shifted;
  logic [63:0]     w_extended;

  assign w_head   = r_queue[r_rd_ptr];
  assign w_full   = (r_count == CW'(PENDING_DEPTH));
  assign w_pop    = bus.read_data_valid && (r_count != '0);
  // A pop of either kind frees a slot, so a full queue may still accept.
  assign w_push   = bus.issue_read && !bus.stall && (!w_full || w_deq);

`ifdef LOAD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_timer;
  logic          r_load_timeout;

  // A same-cycle return takes priority over expiry.
  assign w_expire = (r_count != '0) && (r_timer == TW'(TIMEOUT_CYCLES)) && !bus.read_data_valid;
  assign w_deq    = w_pop || w_expire;

  // Age of the head entry; restarts whenever a new entry becomes head.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer        <= '0;
      r_load_timeout <= 1'b0;
    end else begin
      r_load_timeout <= w_expire;
      if (w_deq || (w_push && r_count == '0))
        r_timer <= '0;
      else if (r_count != '0)
        r_timer <= r_timer + TW'(1);
    end
  end

  assign bus.load_timeout = r_load_timeout;
`else
  assign w_expire         = 1'b0;
  assign w_deq            = w_pop;
  assign bus.load_timeout = 1'b0;
`endif

  // Bring the requested byte to bit 0; bytes past the word read as zero.
  assign w_shifted = bus.read_data >> {w_head.offset, 3'b000};

  // Select the field width and extend it to 64 bits.
  always_comb begin
    // NOTE: default first so every path assigns w_extended and no latch is inferred.
    w_extended = w_shifted;
    unique case (w_head.width)
      WIDTH_B: w_extended = w_head.is_unsigned ? {56'b0, w_shifted[7:0]}
                                               : {{56{w_shifted[7]}}, w_shifted[7:0]};
      WIDTH_H: w_extended = w_head.is_unsigned ? {48'b0, w_shifted[15:0]}
                                               : {{48{w_shifted[15]}}, w_shifted[15:0]};
      WIDTH_W: w_extended = w_head.is_unsigned ? {32'b0, w_shifted[31:0]}
                                               : {{32{w_shifted[31]}}, w_shifted[31:0]};
      WIDTH_D: w_extended = w_shifted;
    endcase
  end

  // Metadata storage; validity is tracked by the pointers and count alone.
  always_ff @(posedge clock) begin
    // NOTE: the entry array is deliberately not reset; r_count masks stale entries.
    if (w_push)
      r_queue[r_wr_ptr] <= '{width:       mem_width_t'(bus.issue_width),
                             is_unsigned: bus.issue_unsigned,
                             offset:      bus.issue_offset,
                             rd:          bus.issue_rd};
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq)  r_rd_ptr <= r_rd_ptr + PW'(1);
      unique case ({w_push, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered writeback result, one cycle after the return.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_load_valid <= 1'b0;
      r_load_rd    <= '0;
      r_load_value <= '0;
    end else begin
      r_load_valid <= w_pop;
      if (w_pop) begin
        r_load_rd    <= w_head.rd;
        r_load_value <= w_extended;
      end
    end
  end

  assign bus.load_valid               = r_load_valid;
  assign bus.load_rd                  = r_load_rd;
  assign bus.load_value               = r_load_value;
  assign bus.outstanding              = r_count;
  assign bus.stall_for_memory_pending = w_full;

endmodule

// File: tb/tb_clarvi_load_unit.sv
// tb_clarvi_load_unit: table of single-load alignment/extension vectors plus
// hand-written queue, reset and timeout sequences. Expected results go into a
// scoreboard queue when the return is driven and are compared on load_valid.
module tb_clarvi_load_unit;

  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 4;

  localparam logic [1:0] B = 2'd0, H = 2'd1, W = 2'd2, D = 2'd3;

  typedef struct {
    logic [1:0]  width;
    logic        uns;
    logic [2:0]  off;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] value;
  } result_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  result_t sb[$];

  clarvi_load_unit_if #(.PENDING_DEPTH(DEPTH)) bus ();

  clarvi_load_unit #(
    .PENDING_DEPTH  (DEPTH),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Scoreboard: every load_valid must match the oldest expected result.
  always @(negedge clock) begin
    if (!reset && bus.load_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_load_valid actual rd=%0d value=%h required no result",
                 bus.load_rd, bus.load_value);
      end else begin
        result_t e;
        e = sb.pop_front();
        check("load_rd", 64'(bus.load_rd), 64'(e.rd));
        check("load_value", bus.load_value, e.value);
      end
    end
  end

  task automatic set_issue(input logic [1:0] width, input logic uns,
                           input logic [2:0] off, input logic [4:0] rd);
    bus.issue_read     = 1'b1;
    bus.issue_width    = width;
    bus.issue_unsigned = uns;
    bus.issue_offset   = off;
    bus.issue_rd       = rd;
  endtask

  task automatic set_return(input logic [63:0] data, input bit expect_result,
                            input logic [4:0] rd, input logic [63:0] value);
    result_t e;
    bus.read_data       = data;
    bus.read_data_valid = 1'b1;
    if (expect_result) begin
      e.rd    = rd;
      e.value = value;
      sb.push_back(e);
    end
  endtask

  // Advance one clock; inputs settle #1 after the edge, then go idle.
  task automatic step();
    if (bus.issue_read && !bus.stall && bus.stall_for_memory_pending && !bus.read_data_valid) begin
      checks++;
      errors++;
      $display("FAIL protocol_issue_while_full actual=1 required=0");
    end
    @(posedge clock);
    #1;
    bus.issue_read      = 1'b0;
    bus.read_data_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[10];
    vecs[0] = '{B, 1'b0, 3'd3, 5'd1,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80};
    vecs[1] = '{H, 1'b1, 3'd6, 5'd2,  64'hBEEF_0000_0000_0000, 64'h0000_0000_0000_BEEF};
    vecs[2] = '{W, 1'b0, 3'd4, 5'd3,  64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321};
    vecs[3] = '{D, 1'b0, 3'd0, 5'd4,  64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{B, 1'b1, 3'd7, 5'd6,  64'hF000_0000_0000_0000, 64'h0000_0000_0000_00F0};
    vecs[5] = '{H, 1'b0, 3'd7, 5'd7,  64'h8000_0000_0000_0000, 64'h0000_0000_0000_0080};
    vecs[6] = '{W, 1'b1, 3'd0, 5'd8,  64'h0000_0000_FFFF_FFFE, 64'h0000_0000_FFFF_FFFE};
    vecs[7] = '{D, 1'b1, 3'd2, 5'd10, 64'h1122_3344_5566_7788, 64'h0000_1122_3344_5566};
    vecs[8] = '{H, 1'b0, 3'd0, 5'd31, 64'hAAAA_AAAA_AAAA_7FFF, 64'h0000_0000_0000_7FFF};
    vecs[9] = '{W, 1'b0, 3'd1, 5'd11, 64'h0000_00FF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FFFF};

    bus.stall           = 1'b0;
    bus.issue_read      = 1'b0;
    bus.issue_width     = B;
    bus.issue_unsigned  = 1'b0;
    bus.issue_offset    = '0;
    bus.issue_rd        = '0;
    bus.read_data       = '0;
    bus.read_data_valid = 1'b0;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_load_valid",   64'(bus.load_valid), 64'd0);
    check("reset_load_rd",      64'(bus.load_rd), 64'd0);
    check("reset_load_value",   bus.load_value, 64'd0);
    check("reset_outstanding",  64'(bus.outstanding), 64'd0);
    check("reset_stall_pend",   64'(bus.stall_for_memory_pending), 64'd0);
    check("reset_load_timeout", 64'(bus.load_timeout), 64'd0);

    // Single loads: issue, return, result exactly one cycle after return.
    for (int i = 0; i < 10; i++) begin
      set_issue(vecs[i].width, vecs[i].uns, vecs[i].off, vecs[i].rd);
      step();
      set_return(vecs[i].data, 1'b1, vecs[i].rd, vecs[i].exp);
      step();
      check("latency_load_valid", 64'(bus.load_valid), 64'd1);
      step();
      check("vector_drained", 64'(sb.size()), 64'd0);
    end

    // Pipeline stall blocks acceptance of an issue.
    bus.stall = 1'b1;
    set_issue(D, 1'b0, 3'd0, 5'd15);
    step();
    bus.stall = 1'b0;
    check("stall_blocks_issue", 64'(bus.outstanding), 64'd0);

    // Fill the queue, then drain with back-to-back returns.
    set_issue(D, 1'b0, 3'd0, 5'd5);
    step();
    set_issue(D, 1'b0, 3'd0, 5'd9);
    step();
    check("full_outstanding", 64'(bus.outstanding), 64'd2);
    check("full_stall",       64'(bus.stall_for_memory_pending), 64'd1);
    set_return(64'h5555_0000_0000_0005, 1'b1, 5'd5, 64'h5555_0000_0000_0005);
    step();
    check("stall_drops",      64'(bus.stall_for_memory_pending), 64'd0);
    check("b2b_first_valid",  64'(bus.load_valid), 64'd1);
    set_return(64'h9999_0000_0000_0009, 1'b1, 5'd9, 64'h9999_0000_0000_0009);
    step();
    check("b2b_second_valid", 64'(bus.load_valid), 64'd1);
    step();
    check("b2b_empty",        64'(bus.outstanding), 64'd0);
    check("b2b_idle",         64'(bus.load_valid), 64'd0);

    // Full queue with issue and return in the same cycle.
    set_issue(D, 1'b0, 3'd0, 5'd20);
    step();
    set_issue(D, 1'b0, 3'd0, 5'd21);
    step();
    set_issue(B, 1'b1, 3'd1, 5'd22);
    set_return(64'h0000_0000_0000_2020, 1'b1, 5'd20, 64'h0000_0000_0000_2020);
    step();
    check("push_pop_outstanding", 64'(bus.outstanding), 64'd2);
    check("push_pop_stall",        64'(bus.stall_for_memory_pending), 64'd1);
    set_return(64'h0000_0000_0000_2121, 1'b1, 5'd21, 64'h0000_0000_0000_2121);
    step();
    set_return(64'h0000_0000_0000_ABCD, 1'b1, 5'd22, 64'h0000_0000_0000_00AB);
    step();
    step();
    check("push_pop_drained", 64'(bus.outstanding), 64'd0);

    // Spurious return on an empty queue.
    set_return(64'hDEAD_BEEF_DEAD_BEEF, 1'b0, 5'd0, 64'd0);
    step();
    check("spurious_no_valid",   64'(bus.load_valid), 64'd0);
    check("spurious_outstanding", 64'(bus.outstanding), 64'd0);

    // Reset with one entry pending, return arrives after reset.
    set_issue(W, 1'b0, 3'd0, 5'd13);
    step();
    check("pre_reset_outstanding", 64'(bus.outstanding), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_return(64'h0000_0000_1234_5678, 1'b0, 5'd0, 64'd0);
    step();
    check("post_reset_no_valid",    64'(bus.load_valid), 64'd0);
    check("post_reset_outstanding", 64'(bus.outstanding), 64'd0);

`ifdef LOAD_TIMEOUT_EN
    // Abandoned head entry.
    begin
      bit seen = 1'b0;
      int when = 0;
      set_issue(D, 1'b0, 3'd0, 5'd14);
      step();
      for (int i = 1; i <= 12 && !seen; i++) begin
        step();
        if (bus.load_timeout === 1'b1) begin
          seen = 1'b1;
          when = i;
        end
      end
      check("timeout_seen",        64'(seen), 64'd1);
      check("timeout_cycle",       64'(when), 64'd5);
      check("timeout_outstanding", 64'(bus.outstanding), 64'd0);
      check("timeout_no_valid",    64'(bus.load_valid), 64'd0);
      step();
      check("timeout_pulse_ends",  64'(bus.load_timeout), 64'd0);
    end
`else
    // Without the timeout an entry waits indefinitely.
    set_issue(D, 1'b0, 3'd0, 5'd14);
    step();
    repeat (20) step();
    check("no_timeout_outstanding", 64'(bus.outstanding), 64'd1);
    check("no_timeout_pulse",       64'(bus.load_timeout), 64'd0);
    set_return(64'h0000_0000_0000_0E0E, 1'b1, 5'd14, 64'h0000_0000_0000_0E0E);
    step();
    step();
    check("late_return_drained", 64'(bus.outstanding), 64'd0);
`endif

    step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clarvi_load_unit.md
# clarvi_load_unit

Load-return stage sitting directly downstream of the MMU/memory-request stage in the clarvi pipeline. Records metadata for every issued read (byte offset, width, signedness, destination register) in a small in-order queue. When the 64-bit word returns from data memory, it aligns and extends the requested field and presents a registered writeback result. Back-pressures the request stage via `stall_for_memory_pending` when the queue is full.

## Interface
- `PENDING_DEPTH`, default 2: number of outstanding loads tracked; power of two, ≥2.
- `TIMEOUT_CYCLES`, default 255: cycles a head entry may wait before being abandoned (only with `LOAD_TIMEOUT_EN`).
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `stall`  in  1  pipeline stall; gates acceptance of new issues only.
- `issue_read`  in  1  read request issued this cycle (MMU `main_read_enable`).
- `issue_width`  in  `mem_width_t`  B/H/W/D access width.
- `issue_unsigned`  in  1  zero-extend (LBU/LHU/LWU) when 1, sign-extend when 0.
- `issue_offset`  in  3  byte offset within the 64-bit word (MMU `word_offset`).
- `issue_rd`  in  5  destination register.
- `read_data`  in  64  data memory return word.
- `read_data_valid`  in  1  `read_data` valid this cycle; returns are in issue order.
- `load_valid`  out  1  one-cycle pulse: `load_rd`/`load_value` valid.
- `load_rd`  out  5  destination register of completed load.
- `load_value`  out  64  aligned, extended load result.
- `stall_for_memory_pending`  out  1  queue full; request stage must not issue.
- `outstanding`  out  $clog2(PENDING_DEPTH)+1  current queue occupancy.
- `load_timeout`  out  1  one-cycle pulse: head entry abandoned.

## Operation
- Queue: circular buffer, read/write pointers wrap modulo `PENDING_DEPTH`; entry = {width, unsigned, offset, rd}.
- Push: `issue_read && !stall` and (occupancy < `PENDING_DEPTH` or a pop occurs the same cycle). Issue while full with no pop: dropped (protocol violation; bench asserts it never happens).
- Pop: `read_data_valid` with occupancy > 0. `read_data_valid` with empty queue: ignored, no output.
- Simultaneous push and pop: occupancy unchanged; push into empty queue with same-cycle return is not forwarded (return belongs to no entry, ignored).
- Alignment: `shifted = read_data >> (offset*8)`; field = low 8/16/32/64 bits of `shifted` for B/H/W/D; bits beyond byte 7 read as zero (misaligned fields crossing the word are truncated, no fault).
- Extension: sign-extend from bit 7/15/31 unless `issue_unsigned`; D ignores `issue_unsigned`.
- `stall` does not affect pops or outputs; writeback consumes `load_valid` unconditionally.
- `stall_for_memory_pending` = (occupancy == `PENDING_DEPTH`), combinational from registered occupancy.

## Timing
- Reset values: `load_valid` 0, `load_rd` 0, `load_value` 0, `load_timeout` 0, `outstanding` 0, pointers 0, timeout counter 0.
- Reset mid-operation: all queued entries discarded; returns arriving after reset ignored.
- Return-to-result latency: 1 cycle (`read_data_valid` at cycle N → `load_valid` at N+1).
- Issue-to-occupancy: registered; `outstanding` and `stall_for_memory_pending` reflect a push from cycle N at N+1.
- Back-to-back returns on consecutive cycles: one `load_valid` per cycle, no bubbles.

## Configuration
- `LOAD_TIMEOUT_EN` defined: counter runs while occupancy > 0 and clears on each pop or on push into empty queue. On reaching `TIMEOUT_CYCLES` with no return that cycle: head popped, `load_timeout` pulses next cycle, `load_valid` stays 0, counter clears. Return in the same cycle as expiry wins (normal pop).
- Not defined: no counter; `load_timeout` tied 0; entries wait indefinitely.

## Test plan
- LB offset 3, sign: `read_data`=64'h0000_0000_8000_0000 with byte3 = 8'h80 → `load_value`=64'hFFFF_FFFF_FFFF_FF80, `load_valid` one cycle after return.
- LHU offset 6, `read_data`=64'hBEEF_0000_0000_0000 → 64'h0000_0000_0000_BEEF; LW offset 4 of 64'h8765_4321_0000_0000 → 64'hFFFF_FFFF_8765_4321.
- Two issues (rd=5, rd=9) with no return → `outstanding`=2, `stall_for_memory_pending`=1; two returns on consecutive cycles → results rd=5 then rd=9, stall drops the cycle after first return.
- Full queue, issue + return same cycle → push accepted, `outstanding` stays 2; spurious `read_data_valid` on empty queue → no `load_valid`.
- Reset asserted with 1 entry pending, return next cycle → no `load_valid`, `outstanding`=0.
- `LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4: one issue, no return → `load_timeout` pulse after 4 waiting cycles, `outstanding`=0, no `load_valid`.
